uart_tx_buffered: RTL and testbench
===================================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning the payload bits per frame.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of transmit buffer entries (power of two, minimum 2).
REQ-003 The block SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port baud_clk  input  1  a one-clk-cycle enable pulse, synchronous to clk, issued once per bit period.
REQ-006 The block SHALL have port data_in  input  DATA_BITS  the byte to enqueue.
REQ-007 The block SHALL have port tx_start  input  1  an enqueue strobe; each clk cycle it is high is one write request.
REQ-008 The block SHALL have port cts  input  1  peer clear-to-send; high permits a new frame to start.
REQ-009 The block SHALL have port tx  output  1  the serial line, idle high.
REQ-010 The block SHALL have port tx_ready  output  1  high when the FIFO is not full.
REQ-011 The block SHALL have port tx_buffer_empty  output  1  high when the FIFO holds no entries.
REQ-012 The block SHALL have port tx_busy  output  1  high while the FSM is outside IDLE.

Function
REQ-013 Frame format SHALL be 8N1-style: one start bit (0), DATA_BITS data bits LSB first, one stop bit (1), each lasting exactly one baud_clk period.
REQ-014 The FSM SHALL have four states, IDLE, START, DATA and STOP, and SHALL change state only on clk edges where baud_clk=1.
REQ-015 In IDLE with FIFO non-empty, cts=1 and baud_clk=1, the block SHALL pop the head entry into a shift register, drive tx=0 and enter START, all on the same edge.
REQ-016 In START, on baud_clk, the block SHALL drive tx=bit0, clear the bit counter and enter DATA.
REQ-017 In DATA, on each baud_clk, the block SHALL shift out the next bit; after bit DATA_BITS-1 has completed one period, it SHALL drive tx=1 and enter STOP.
REQ-018 In STOP, on baud_clk, the block SHALL either pop and start the next frame directly (tx=0, enter START) when the FIFO is non-empty and cts=1, or otherwise enter IDLE with tx=1.
REQ-019 A back-to-back frame SHALL follow with zero idle bit periods, giving 10 bit periods per byte for DATA_BITS=8.
REQ-020 cts SHALL be sampled only at frame start; deassertion mid-frame SHALL NOT abort or stretch the current frame.
REQ-021 tx SHALL be a registered output, glitch-free, and high whenever the FSM is in IDLE.
REQ-022 A push SHALL occur when tx_start=1 and the registered count is below FIFO_DEPTH; when full, tx_start SHALL be ignored and the data dropped, even if a pop happens in the same cycle.
REQ-023 A simultaneous push and pop SHALL leave the count unchanged and preserve FIFO order.
REQ-024 A pop SHALL require count>0 before the edge; a byte pushed into an empty FIFO SHALL NOT be popped on the same edge (no fall-through), so the earliest it can start is the next baud_clk.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-026 tx_ready and tx_buffer_empty SHALL be derived from the registered count and reflect it in the cycle after each push or pop.
REQ-027 baud_clk held high for several cycles SHALL advance the FSM once per cycle; the block SHALL NOT detect edges on it.

Reset
REQ-028 Asserting rst SHALL immediately set tx=1, FSM=IDLE, tx_busy=0, count=0, pointers=0, tx_ready=1, tx_buffer_empty=1 and the shift register and bit counter to 0.
REQ-029 Reset mid-frame SHALL abort the frame and discard all buffered bytes; the line SHALL go high without completing the stop bit.
REQ-030 After rst deasserts, no frame SHALL start before the first baud_clk pulse with FIFO non-empty and cts=1.

Structure
REQ-031 The state enum tx_state_t (IDLE, START, DATA, STOP) and the line levels UART_IDLE=1, UART_START=0 SHALL live in the shared package uart_pkg, also used by uart_rx.
REQ-032 The FIFO SHALL be a sub-module named tx_fifo (parameters DATA_WIDTH, DEPTH; ports push, pop, din, dout, full, empty); the serializer FSM stays in uart_tx_buffered.

Verification
REQ-033 Single byte: push 0xA5 with cts=1 and baud_clk every 16 clk cycles -> tx bit sequence 0,1,0,1,0,0,1,0,1,1 at the bit periods; tx_busy drops after the stop bit.
REQ-034 Back-to-back: push 0x00, 0xFF, 0x55, 0x0F in four consecutive cycles -> tx_ready low after the 4th push, then 40 contiguous bit periods with no idle gap, bytes in order.
REQ-035 Overflow: with cts=0, push 5 bytes 0x01..0x05 -> 5th dropped; on raising cts, only 0x01..0x04 are transmitted.
REQ-036 Flow control: drop cts during the 3rd data bit of 0x3C -> frame completes intact; the next queued 0x99 does not start until cts=1.
REQ-037 Reset mid-frame: assert rst during bit 4 of 0xC3 with 2 bytes queued -> tx=1 at once, tx_buffer_empty=1, no further frames after release.
REQ-038 Full plus simultaneous: with the FIFO full, tx_start coincides with the STOP-end pop -> the push is dropped, count becomes 3 and tx_ready rises the next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and serial line levels.
// Used by both the buffered transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Transmit buffer: circular FIFO with a registered occupancy count.
// Full/empty come from the count alone, so a push into an empty FIFO is never visible to pop on the same edge.
module tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [COUNT_W-1:0]    count;
  logic                  wr_ok;
  logic                  rd_ok;

  // A full FIFO refuses the write even when a pop frees a slot on the same edge.
  assign wr_ok = push && !full;
  assign rd_ok = pop && !empty;

  assign full  = (count == COUNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed 8N1-style serializer paced by a baud enable pulse.
// Frames chain with no idle period whenever data is queued and the peer allows it.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 tx_start,
  input  logic                 cts,
  output logic                 tx,
  output logic                 tx_ready,
  output logic                 tx_buffer_empty,
  output logic                 tx_busy
);

  localparam int                CNT_W    = cnt_width(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 frame_go;
  logic                 fifo_pop;

  tx_fifo #(
    .DATA_WIDTH (DATA_BITS),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_start),
    .pop   (fifo_pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // cts only matters at a frame boundary (IDLE or end of STOP).
  assign frame_go = cts && !fifo_empty;
  assign fifo_pop = baud_clk && frame_go && ((state == IDLE) || (state == STOP));

  assign tx_ready        = !fifo_full;
  assign tx_buffer_empty = fifo_empty;
  assign tx_busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= UART_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (baud_clk) begin
      case (state)
        IDLE: begin
          if (frame_go) begin
            shift_reg <= fifo_dout;
            tx        <= UART_START;
            state     <= START;
          end else begin
            tx <= UART_IDLE;
          end
        end
        START: begin
          tx        <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= '0;
          state     <= DATA;
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            tx    <= UART_IDLE;
            state <= STOP;
          end else begin
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (frame_go) begin
            shift_reg <= fifo_dout;
            tx        <= UART_START;
            state     <= START;
          end else begin
            tx    <= UART_IDLE;
            state <= IDLE;
          end
        end
        default: begin
          tx    <= UART_IDLE;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed self-checking bench for uart_tx_buffered with a free-running divide-by-16 baud pulse.
// Each scenario task drives its own stimulus and compares against hand-computed frames.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_clk;
  logic [7:0] data_in;
  logic       tx_start;
  logic       cts;
  logic       tx;
  logic       tx_ready;
  logic       tx_buffer_empty;
  logic       tx_busy;

  int checks = 0;
  int errors = 0;
  bit baud_en = 1'b0;
  int baud_cnt = 0;

  uart_tx_buffered #(
    .DATA_BITS  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .baud_clk        (baud_clk),
    .data_in         (data_in),
    .tx_start        (tx_start),
    .cts             (cts),
    .tx              (tx),
    .tx_ready        (tx_ready),
    .tx_buffer_empty (tx_buffer_empty),
    .tx_busy         (tx_busy)
  );

  initial forever #5 clk = ~clk;

  // One-cycle baud pulse every 16 clocks, changed on the falling edge.
  initial begin
    baud_clk = 1'b0;
    forever begin
      @(negedge clk);
      baud_cnt = (baud_cnt == 15) ? 0 : baud_cnt + 1;
      baud_clk = baud_en && (baud_cnt == 15);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Returns 1ns after the next clock edge on which baud_clk is high.
  task automatic next_baud();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!baud_clk && n < 64);
    if (!baud_clk) begin
      checks++;
      errors++;
      $display("[TB] FAIL baud_timeout: no baud pulse within %0d cycles, required one", n);
    end
    #1;
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 24 && !found; i++) begin
      next_baud();
      if (tx === 1'b0) found = 1'b1;
    end
  endtask

  // Samples tx once per bit period, starting with the current (start-bit) level.
  task automatic capture(input int n, output logic [39:0] bits);
    bits    = '1;
    bits[0] = tx;
    for (int i = 1; i < n; i++) begin
      next_baud();
      bits[i] = tx;
    end
  endtask

  task automatic push_bytes(input logic [39:0] vec, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_in  = vec[8*i +: 8];
      tx_start = 1'b1;
    end
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b, expected 1", tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", tx_busy); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b, expected 1", tx_ready); end
    checks++; if (tx_buffer_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b, expected 1", tx_buffer_empty); end
    repeat (3) @(negedge clk);
    rst     = 1'b0;
    cts     = 1'b1;
    baud_en = 1'b1;
    begin
      bit quiet;
      quiet = 1'b1;
      for (int i = 0; i < 3; i++) begin
        next_baud();
        if (tx !== 1'b1 || tx_busy !== 1'b0) quiet = 1'b0;
      end
      checks++; if (!quiet) begin errors++; $display("[TB] FAIL reset_no_frame: got tx=%b busy=%b, expected tx=1 busy=0", tx, tx_busy); end
    end
  endtask

  task automatic test_single_byte();
    bit found;
    logic [39:0] bits;
    @(negedge clk);
    #2;
    data_in  = 8'hA5;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    checks++; if (tx_buffer_empty !== 1'b0) begin errors++; $display("[TB] FAIL single_empty_after_push: got %b, expected 0", tx_buffer_empty); end
    wait_start(found);
    checks++; if (!found) begin errors++; $display("[TB] FAIL single_start: no start bit seen, expected one"); end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b, expected 1", tx_busy); end
    capture(10, bits);
    checks++; if (bits[9:0] !== 10'b1101001010) begin errors++; $display("[TB] FAIL single_bits: got %b, expected %b (time order right to left)", bits[9:0], 10'b1101001010); end
    next_baud();
    checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL single_idle_tx: got %b, expected 1", tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy: got %b, expected 0", tx_busy); end
    checks++; if (tx_buffer_empty !== 1'b1) begin errors++; $display("[TB] FAIL single_idle_empty: got %b, expected 1", tx_buffer_empty); end
  endtask

  task automatic test_back_to_back();
    bit found;
    logic [39:0] bits;
    logic [31:0] exp_bytes;
    exp_bytes = 32'h0F55FF00;
    baud_en = 1'b0;
    push_bytes({8'h00, exp_bytes}, 4);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_full: got %b, expected 0", tx_ready); end
    checks++; if (tx_buffer_empty !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty: got %b, expected 0", tx_buffer_empty); end
    baud_en = 1'b1;
    wait_start(found);
    checks++; if (!found) begin errors++; $display("[TB] FAIL b2b_start: no start bit seen, expected one"); end
    capture(40, bits);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bits[10*k +: 10] !== {1'b1, exp_bytes[8*k +: 8], 1'b0}) begin
        errors++;
        $display("[TB] FAIL b2b_frame%0d: got %b, expected %b", k, bits[10*k +: 10], {1'b1, exp_bytes[8*k +: 8], 1'b0});
      end
    end
    next_baud();
    checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got tx=%b busy=%b, expected tx=1 busy=0", tx, tx_busy); end
  endtask

  task automatic test_overflow();
    bit found;
    logic [39:0] bits;
    logic [39:0] vec;
    vec = 40'h0504030201;
    @(negedge clk);
    cts = 1'b0;
    push_bytes(vec, 5);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL ovf_ready: got %b, expected 0", tx_ready); end
    checks++; if (tx_buffer_empty !== 1'b0) begin errors++; $display("[TB] FAIL ovf_empty: got %b, expected 0", tx_buffer_empty); end
    next_baud();
    next_baud();
    checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL ovf_held_by_cts: got tx=%b busy=%b, expected tx=1 busy=0", tx, tx_busy); end
    @(negedge clk);
    cts = 1'b1;
    wait_start(found);
    checks++; if (!found) begin errors++; $display("[TB] FAIL ovf_start: no start bit seen, expected one"); end
    capture(40, bits);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bits[10*k +: 10] !== {1'b1, vec[8*k +: 8], 1'b0}) begin
        errors++;
        $display("[TB] FAIL ovf_frame%0d: got %b, expected %b", k, bits[10*k +: 10], {1'b1, vec[8*k +: 8], 1'b0});
      end
    end
    next_baud();
    checks++; if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_buffer_empty !== 1'b1) begin errors++; $display("[TB] FAIL ovf_fifth_dropped: got tx=%b busy=%b empty=%b, expected 1 0 1", tx, tx_busy, tx_buffer_empty); end
  endtask

  task automatic test_flow_control();
    bit found;
    bit quiet;
    logic [39:0] bits;
    baud_en = 1'b0;
    push_bytes({24'h0, 8'h99, 8'h3C}, 2);
    baud_en = 1'b1;
    wait_start(found);
    checks++; if (!found) begin errors++; $display("[TB] FAIL flow_start: no start bit seen, expected one"); end
    bits    = '1;
    bits[0] = tx;
    for (int i = 1; i < 10; i++) begin
      next_baud();
      bits[i] = tx;
      if (i == 3) cts = 1'b0;
    end
    checks++; if (bits[9:0] !== 10'b1001111000) begin errors++; $display("[TB] FAIL flow_frame_3c: got %b, expected %b", bits[9:0], 10'b1001111000); end
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_baud();
      if (tx !== 1'b1 || tx_busy !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin errors++; $display("[TB] FAIL flow_hold: got tx=%b busy=%b, expected tx=1 busy=0 while cts=0", tx, tx_busy); end
    checks++; if (tx_buffer_empty !== 1'b0) begin errors++; $display("[TB] FAIL flow_queued: got empty=%b, expected 0", tx_buffer_empty); end
    @(negedge clk);
    cts = 1'b1;
    wait_start(found);
    checks++; if (!found) begin errors++; $display("[TB] FAIL flow_resume: no start bit seen, expected one"); end
    capture(10, bits);
    checks++; if (bits[9:0] !== 10'b1100110010) begin errors++; $display("[TB] FAIL flow_frame_99: got %b, expected %b", bits[9:0], 10'b1100110010); end
    next_baud();
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    bit quiet;
    baud_en = 1'b0;
    push_bytes({16'h0, 8'h22, 8'h11, 8'hC3}, 3);
    baud_en = 1'b1;
    wait_start(found);
    checks++; if (!found) begin errors++; $display("[TB] FAIL rstmid_start: no start bit seen, expected one"); end
    repeat (5) next_baud();
    checks++; if (tx !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_bit4: got %b, expected 0", tx); end
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_tx: got %b, expected 1", tx); end
    checks++; if (tx_buffer_empty !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_empty: got %b, expected 1", tx_buffer_empty); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready: got %b, expected 1", tx_ready); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b, expected 0", tx_busy); end
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 30; i++) begin
      next_baud();
      if (tx !== 1'b1 || tx_busy !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin errors++; $display("[TB] FAIL rstmid_no_frames: got tx=%b busy=%b, expected line idle", tx, tx_busy); end
  endtask

  task automatic test_full_simultaneous();
    bit found;
    bit hit;
    logic [39:0] bits;
    logic [31:0] exp_bytes;
    exp_bytes = 32'h78563412;
    baud_en = 1'b0;
    push_bytes({32'h0, 8'h81}, 1);
    baud_en = 1'b1;
    wait_start(found);
    checks++; if (!found) begin errors++; $display("[TB] FAIL fullsim_start: no start bit seen, expected one"); end
    push_bytes({8'h00, exp_bytes}, 4);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL fullsim_full: got ready=%b, expected 0", tx_ready); end
    repeat (9) next_baud();
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      #2;
      if (baud_clk) begin
        data_in  = 8'hEE;
        tx_start = 1'b1;
        hit      = 1'b1;
      end
    end
    checks++; if (!hit) begin errors++; $display("[TB] FAIL fullsim_align: no baud pulse found, expected one"); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL fullsim_ready_before: got %b, expected 0", tx_ready); end
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    checks++; if (tx !== 1'b0) begin errors++; $display("[TB] FAIL fullsim_next_start: got tx=%b, expected 0", tx); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL fullsim_ready_after: got %b, expected 1", tx_ready); end
    capture(40, bits);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bits[10*k +: 10] !== {1'b1, exp_bytes[8*k +: 8], 1'b0}) begin
        errors++;
        $display("[TB] FAIL fullsim_frame%0d: got %b, expected %b", k, bits[10*k +: 10], {1'b1, exp_bytes[8*k +: 8], 1'b0});
      end
    end
    next_baud();
    checks++; if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_buffer_empty !== 1'b1) begin errors++; $display("[TB] FAIL fullsim_dropped: got tx=%b busy=%b empty=%b, expected 1 0 1", tx, tx_busy, tx_buffer_empty); end
  endtask

  initial begin
    rst      = 1'b1;
    cts      = 1'b0;
    tx_start = 1'b0;
    data_in  = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_flow_control();
    test_reset_mid_frame();
    test_full_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
